// File: rtl/mc_control_fsm.sv
// Multicycle control FSM for the 32-bit MIPS-subset datapath (ALU interface initiator).
// Optional: define MCTRL_BNE_EN to decode bne (opcode 000101) as a branch instead of a trap.
module mc_control_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        iord,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  alusrc_a,
    output logic [1:0]  alusrc_b,
    output logic [3:0]  alusel,
    output logic        regdst,
    output logic        memtoreg,
    output logic        reg_we,
    output logic        err,
    output logic [31:0] instret
);
    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, ALU_WB, EXEC_I, I_WB, MEM_ADDR,
        MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, TRAP
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MCTRL_BNE_EN
    localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0111;
    localparam logic [3:0] ALU_OR  = 4'b1111;
    localparam logic [3:0] ALU_SLT = 4'b1110;
    localparam logic [3:0] ALU_SLL = 4'b1100;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_DEF = 4'b0000;

    state_t     state, nextState;
    logic       retire;
    logic       functOk;
    logic [3:0] rAluSel;
    logic [1:0] rSrcA;
    logic       brTaken;

    // R-type funct decode: operation plus whether A takes rs or shamt
    always_comb begin
        functOk = 1'b1;
        rAluSel = ALU_DEF;
        rSrcA   = 2'd1;
        case (funct)
            6'b100000: rAluSel = ALU_ADD;
            6'b100010: rAluSel = ALU_SUB;
            6'b100100: rAluSel = ALU_AND;
            6'b100101: rAluSel = ALU_OR;
            6'b101010: rAluSel = ALU_SLT;
            6'b000000: begin rAluSel = ALU_SLL; rSrcA = 2'd2; end
            6'b000010: begin rAluSel = ALU_SRL; rSrcA = 2'd2; end
            default:   functOk = 1'b0;
        endcase
    end

`ifdef MCTRL_BNE_EN
    assign brTaken = (opcode == OP_BNE) ? ~alu_zero : alu_zero;
`else
    assign brTaken = alu_zero;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH;
            instret <= '0;
        end else begin
            state <= nextState;
            if (retire)
                instret <= instret + 32'd1;
        end
    end

    always_comb begin
        nextState = state;
        retire    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        iord      = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'd0;
        alusrc_a  = 2'd0;
        alusrc_b  = 2'd0;
        alusel    = ALU_DEF;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        reg_we    = 1'b0;
        err       = 1'b0;
        case (state)
            FETCH: begin
                mem_rd   = 1'b1;
                alusrc_b = 2'd1;
                alusel   = ALU_ADD;
                ir_we    = mem_ready;
                pc_we    = mem_ready;
                if (mem_ready) nextState = DECODE;
            end
            DECODE: begin
                alusrc_b = 2'd3;
                alusel   = ALU_ADD;
                case (opcode)
                    OP_R:         nextState = functOk ? EXEC_R : TRAP;
                    OP_LW, OP_SW: nextState = MEM_ADDR;
                    OP_BEQ:       nextState = BRANCH;
`ifdef MCTRL_BNE_EN
                    OP_BNE:       nextState = BRANCH;
`endif
                    OP_ADDI:      nextState = EXEC_I;
                    OP_J:         nextState = JUMP;
                    default:      nextState = TRAP;
                endcase
            end
            EXEC_R: begin
                alusrc_a  = rSrcA;
                alusel    = rAluSel;
                nextState = ALU_WB;
            end
            ALU_WB: begin
                regdst    = 1'b1;
                reg_we    = 1'b1;
                retire    = 1'b1;
                nextState = FETCH;
            end
            EXEC_I: begin
                alusrc_a  = 2'd1;
                alusrc_b  = 2'd2;
                alusel    = ALU_ADD;
                nextState = I_WB;
            end
            I_WB: begin
                reg_we    = 1'b1;
                retire    = 1'b1;
                nextState = FETCH;
            end
            MEM_ADDR: begin
                alusrc_a  = 2'd1;
                alusrc_b  = 2'd2;
                alusel    = ALU_ADD;
                nextState = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
                if (mem_ready) nextState = MEM_WB;
            end
            MEM_WB: begin
                memtoreg  = 1'b1;
                reg_we    = 1'b1;
                retire    = 1'b1;
                nextState = FETCH;
            end
            MEM_WR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
                if (mem_ready) begin
                    retire    = 1'b1;
                    nextState = FETCH;
                end
            end
            BRANCH: begin
                alusrc_a  = 2'd1;
                alusel    = ALU_SUB;
                pc_src    = 2'd1;
                pc_we     = brTaken;
                retire    = 1'b1;
                nextState = FETCH;
            end
            JUMP: begin
                pc_src    = 2'd2;
                pc_we     = 1'b1;
                retire    = 1'b1;
                nextState = FETCH;
            end
            TRAP: err = 1'b1;
            default: nextState = FETCH;
        endcase
        // Reset forces every strobe and select low without waiting for a clock
        if (rst) begin
            mem_rd   = 1'b0;
            mem_wr   = 1'b0;
            iord     = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            pc_src   = 2'd0;
            alusrc_a = 2'd0;
            alusrc_b = 2'd0;
            alusel   = ALU_DEF;
            regdst   = 1'b0;
            memtoreg = 1'b0;
            reg_we   = 1'b0;
            err      = 1'b0;
        end
    end
endmodule
